add_round_key_stage: RTL and testbench
======================================

ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 Parameter DATA_WIDTH, 128, width of state and key words.
REQ-002 Parameter NUM_ROUNDS, 10, AES-128 round count; only 10 is supported.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port key_load  input  1  high for one cycle loads key_in as the cipher key.
REQ-006 Port key_in  input  DATA_WIDTH  cipher key, sampled only when key_load=1.
REQ-007 Port ark_valid_in  input  1  state_in valid this cycle.
REQ-008 Port state_in  input  DATA_WIDTH  state from the previous stage (plaintext for round 0, SubByte/MixColumn output otherwise).
REQ-009 Port state_out  output  DATA_WIDTH  state_in XOR current round key, registered.
REQ-010 Port ark_valid_out  output  1  state_out valid this cycle.
REQ-011 Port round_out  output  4  round index (0..10) of the beat on state_out.
REQ-012 Port last_round  output  1  high with ark_valid_out when round_out=10 (ciphertext).

Function
REQ-013 The block SHALL hold cipher_key, round_key and a round counter rnd (0..10); round_key for rnd=n SHALL equal FIPS-197 expanded key words w[4n..4n+3].
REQ-014 Latency SHALL be exactly 1 cycle: the beat accepted at edge k appears on state_out/ark_valid_out after edge k.
REQ-015 ark_valid_out SHALL equal ark_valid_in registered; state_out, round_out and last_round SHALL hold their values when ark_valid_in=0.
REQ-016 On an accepted beat: state_out <= state_in ^ round_key, round_out <= rnd, then round_key <= expand(round_key, RCON[rnd+1]) and rnd <= rnd+1.
REQ-017 Beat with rnd=10 SHALL raise last_round, then wrap: rnd <= 0, round_key <= cipher_key (ready for the next block without reload).
REQ-018 expand() SHALL be the AES-128 step: t = SubWord(RotWord(w3)) ^ {Rcon,00,00,00}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-019 RCON sequence SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-020 key_load alone: cipher_key <= key_in, round_key <= key_in, rnd <= 0; no output change.
REQ-021 key_load with ark_valid_in in the same cycle: the beat SHALL be processed as round 0 with key_in (state_out = state_in ^ key_in), cipher_key <= key_in, round_key <= expand(key_in, 01), rnd <= 1.
REQ-022 key_load mid-sequence (rnd 1..10) SHALL abort the current block; the next beat is round 0 of the new key.
REQ-023 No backpressure: the stage SHALL accept one beat per cycle; back-to-back beats on consecutive cycles SHALL be legal.

Reset
REQ-024 rst=0 SHALL asynchronously clear state_out, round_out, last_round, ark_valid_out, rnd, cipher_key and round_key to 0.
REQ-025 Reset mid-block SHALL discard the sequence; a beat before a new key_load uses an all-zero key.
REQ-026 Release of reset SHALL take effect at the first rising edge of clk with rst=1.

Structure
REQ-027 A shared package aes_pkg SHALL hold the 256-entry SBOX table, the RCON table, NUM_ROUNDS and the state/word widths.
REQ-028 One sub-module key_expand_step SHALL implement the combinational expand() step (inputs round_key, rcon; output next key).
REQ-029 Only round_key, cipher_key, rnd and the output registers SHALL be sequential; the S-box lookup SHALL be combinational from aes_pkg.

Verification
REQ-030 key_load key=2b7e151628aed2a6abf7158809cf4f3c, then beat state_in=3243f6a8885a308d313198a2e0370734 -> next cycle state_out=193de3bea0f4e22b9ac68d2ae9f84808, round_out=0.
REQ-031 Same key, 11 beats of 0 -> state_out equals round keys in order; beat 1 = a0fafe1788542cb123a339392a6c7605, beat 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with last_round=1.
REQ-032 Twelfth zero beat, no reload -> state_out=2b7e151628aed2a6abf7158809cf4f3c, round_out=0 (wrap).
REQ-033 key_load + ark_valid_in same cycle, key 000102030405060708090a0b0c0d0e0f, state 00112233445566778899aabbccddeeff -> state_out=00102030405060708090a0b0c0d0e0f0, following beat round_out=1.
REQ-034 Assert rst=0 asynchronously after beat 5 -> all outputs 0 immediately; after release, zero beat -> state_out=0, round_out=0.
REQ-035 Gaps: ark_valid_in toggling 1,0,1 -> ark_valid_out 1,0,1 one cycle later; state_out and round_out stable in gap.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants shared by the add-round-key stage: widths, S-box, round constants.
package aes_pkg;

    localparam int STATE_WIDTH = 128;
    localparam int WORD_WIDTH  = 32;
    localparam int NUM_ROUNDS  = 10;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // RCON[i] is the round constant used to derive the key for round i+1.
    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    function automatic logic [WORD_WIDTH-1:0] sub_word(input logic [WORD_WIDTH-1:0] w);
        sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_for(input logic [3:0] rnd);
        rcon_for = (rnd < 4'(NUM_ROUNDS)) ? RCON[rnd] : 8'h00;
    endfunction

endpackage

// File: rtl/key_expand_step.sv
// rtl/key_expand_step.sv - combinational AES-128 key schedule step: current round key to next round key.
module key_expand_step
    import aes_pkg::*;
(
    input  logic [STATE_WIDTH-1:0] round_key,
    input  logic [7:0]             rcon,
    output logic [STATE_WIDTH-1:0] next_key
);

    logic [WORD_WIDTH-1:0] w0, w1, w2, w3;
    logic [WORD_WIDTH-1:0] t;
    logic [WORD_WIDTH-1:0] n0, n1, n2, n3;

    always_comb begin
        {w0, w1, w2, w3} = round_key;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/add_round_key_stage.sv
// rtl/add_round_key_stage.sv - registered AddRoundKey stage with on-the-fly AES-128 key schedule.
module add_round_key_stage #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_load,
    input  logic [DATA_WIDTH-1:0] key_in,
    input  logic                  ark_valid_in,
    input  logic [DATA_WIDTH-1:0] state_in,
    output logic [DATA_WIDTH-1:0] state_out,
    output logic                  ark_valid_out,
    output logic [3:0]            round_out,
    output logic                  last_round
);

    logic [DATA_WIDTH-1:0] cipher_key_q, cipher_key_d;
    logic [DATA_WIDTH-1:0] round_key_q,  round_key_d;
    logic [3:0]            rnd_q,        rnd_d;
    logic [DATA_WIDTH-1:0] state_out_q,  state_out_d;
    logic [3:0]            round_out_q,  round_out_d;
    logic                  last_round_q, last_round_d;
    logic                  valid_q,      valid_d;

    logic [DATA_WIDTH-1:0] exp_in;
    logic [DATA_WIDTH-1:0] exp_out;
    logic [7:0]            exp_rcon;

    // A single expander serves both the fresh-key path and the running schedule.
    key_expand_step u_key_expand_step (
        .round_key (exp_in),
        .rcon      (exp_rcon),
        .next_key  (exp_out)
    );

    always_comb begin
        exp_in       = key_load ? key_in : round_key_q;
        exp_rcon     = key_load ? aes_pkg::RCON[0] : aes_pkg::rcon_for(rnd_q);

        cipher_key_d = cipher_key_q;
        round_key_d  = round_key_q;
        rnd_d        = rnd_q;
        state_out_d  = state_out_q;
        round_out_d  = round_out_q;
        last_round_d = last_round_q;
        valid_d      = ark_valid_in;

        if (key_load && ark_valid_in) begin
            cipher_key_d = key_in;
            state_out_d  = state_in ^ key_in;
            round_out_d  = 4'd0;
            last_round_d = 1'b0;
            round_key_d  = exp_out;
            rnd_d        = 4'd1;
        end else if (key_load) begin
            cipher_key_d = key_in;
            round_key_d  = key_in;
            rnd_d        = 4'd0;
        end else if (ark_valid_in) begin
            state_out_d  = state_in ^ round_key_q;
            round_out_d  = rnd_q;
            last_round_d = (rnd_q == 4'(NUM_ROUNDS));
            if (rnd_q == 4'(NUM_ROUNDS)) begin
                round_key_d = cipher_key_q;
                rnd_d       = 4'd0;
            end else begin
                round_key_d = exp_out;
                rnd_d       = rnd_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cipher_key_q <= '0;
            round_key_q  <= '0;
            rnd_q        <= '0;
            state_out_q  <= '0;
            round_out_q  <= '0;
            last_round_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            cipher_key_q <= cipher_key_d;
            round_key_q  <= round_key_d;
            rnd_q        <= rnd_d;
            state_out_q  <= state_out_d;
            round_out_q  <= round_out_d;
            last_round_q <= last_round_d;
            valid_q      <= valid_d;
        end
    end

    assign state_out     = state_out_q;
    assign ark_valid_out = valid_q;
    assign round_out     = round_out_q;
    assign last_round    = last_round_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb/tb_add_round_key_stage.sv - self-checking bench for add_round_key_stage against FIPS-197 vectors.
module tb_add_round_key_stage;

    logic         clk;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic         ark_valid_in;
    logic [127:0] state_in;
    logic [127:0] state_out;
    logic         ark_valid_out;
    logic [3:0]   round_out;
    logic         last_round;

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] rk [0:10];
    logic [127:0] key_a;
    logic [127:0] held;

    add_round_key_stage #(.DATA_WIDTH(128), .NUM_ROUNDS(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_load      (key_load),
        .key_in        (key_in),
        .ark_valid_in  (ark_valid_in),
        .state_in      (state_in),
        .state_out     (state_out),
        .ark_valid_out (ark_valid_out),
        .round_out     (round_out),
        .last_round    (last_round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && ark_valid_out === 1'b1) begin
            chk("sb_has_entry", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("state_out r%0d", e.rnd), state_out, e.st);
                chk($sformatf("round_out r%0d", e.rnd), 128'(round_out), 128'(e.rnd));
                chk($sformatf("last_round r%0d", e.rnd), 128'(last_round), 128'(e.last));
            end
        end
    end

    task automatic beat(input logic [127:0] d, input logic [127:0] es, input logic [3:0] er, input logic el);
        exp_t e;
        @(posedge clk);
        #1;
        key_load     = 1'b0;
        ark_valid_in = 1'b1;
        state_in     = d;
        e.st = es; e.rnd = er; e.last = el;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        key_load     = 1'b0;
        ark_valid_in = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] k);
        @(posedge clk);
        #1;
        key_load     = 1'b1;
        key_in       = k;
        ark_valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        key_a  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[0]  = key_a;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b0; key_load = 1'b0; key_in = '0; ark_valid_in = 1'b0; state_in = '0;
        @(negedge clk);
        chk("reset valid_out", 128'(ark_valid_out), 128'd0);
        chk("reset state_out", state_out, 128'd0);
        chk("reset round_out", 128'(round_out), 128'd0);
        chk("reset last_round", 128'(last_round), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // key_load alone leaves outputs untouched
        load_key(key_a);
        idle();
        @(negedge clk);
        chk("keyload valid_out", 128'(ark_valid_out), 128'd0);
        chk("keyload state_out", state_out, 128'd0);

        beat(128'h3243f6a8885a308d313198a2e0370734, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0, 1'b0);

        // full schedule, back-to-back, then wrap without reload
        load_key(key_a);
        for (int i = 0; i <= 10; i++) beat('0, rk[i], 4'(i), (i == 10));
        beat('0, key_a, 4'd0, 1'b0);

        // gap: valid 1,0,1
        beat('0, rk[1], 4'd1, 1'b0);
        idle();
        @(negedge clk);
        chk("gap valid_out first", 128'(ark_valid_out), 128'd1);
        held = state_out;
        beat('0, rk[2], 4'd2, 1'b0);
        @(negedge clk);
        chk("gap valid_out hole", 128'(ark_valid_out), 128'd0);
        chk("gap state_out held", state_out, rk[1]);
        chk("gap round_out held", 128'(round_out), 128'd1);
        idle();
        @(negedge clk);
        chk("gap valid_out second", 128'(ark_valid_out), 128'd1);

        // key_load together with a beat
        @(posedge clk);
        #1;
        key_load = 1'b1; key_in = 128'h000102030405060708090a0b0c0d0e0f;
        ark_valid_in = 1'b1; state_in = 128'h00112233445566778899aabbccddeeff;
        e.st = 128'h00102030405060708090a0b0c0d0e0f0; e.rnd = 4'd0; e.last = 1'b0;
        sb.push_back(e);
        beat('0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 4'd1, 1'b0);

        // async reset mid-block
        load_key(key_a);
        for (int i = 0; i < 5; i++) beat('0, rk[i], 4'(i), 1'b0);
        idle();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst valid_out", 128'(ark_valid_out), 128'd0);
        chk("async rst state_out", state_out, 128'd0);
        chk("async rst round_out", 128'(round_out), 128'd0);
        chk("async rst last_round", 128'(last_round), 128'd0);
        chk("queue drained before rst", 128'(sb.size()), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        beat('0, '0, 4'd0, 1'b0);
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("queue drained at end", 128'(sb.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
